// File: rtl/fetch_stage.sv
// Instruction-fetch stage with IF/ID pipeline register for the five-stage RV32 pipeline.
// Issues one request at a time to a variable-latency instruction memory.
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  input  logic        StallD,
  input  logic        FlushD,
  input  logic        PCSrcE,
  input  logic [31:0] PCTargetE,
  output logic [31:0] InstrD,
  output logic [31:0] PCD,
  output logic [31:0] PCPlus4D,
  output logic        ValidD
);

  typedef enum logic [1:0] {IDLE, FETCH, HOLD} state_t;
  typedef enum logic [1:0] {IFID_HOLD, IFID_BUBBLE, IFID_FETCH, IFID_BUF} ifid_sel_t;

  state_t      state_reg, state_next;
  ifid_sel_t   ifid_sel;

  logic [31:0] pcf_reg, pcf_next;
  logic        redir_pend_reg, redir_pend_next;
  logic [31:0] redir_pc_reg, redir_pc_next;
  logic [31:0] buf_instr_reg, buf_instr_next;
  logic [31:0] buf_pc_reg, buf_pc_next;

  logic [31:0] instr_d_reg, instr_d_next;
  logic [31:0] pc_d_reg, pc_d_next;
  logic [31:0] pc_plus4_d_reg, pc_plus4_d_next;
  logic        valid_d_reg, valid_d_next;

  logic [31:0] target_e;
  logic [31:0] pcf_plus4;
  logic [31:0] buf_pc_plus4;
  logic        keep_d;

  assign target_e     = PCTargetE & ~32'd3;
  assign pcf_plus4    = pcf_reg + 32'd4;
  assign buf_pc_plus4 = buf_pc_reg + 32'd4;
  // IF/ID holds only when stalled and not flushed; otherwise it takes a bubble
  assign keep_d       = StallD & ~FlushD;

  assign imem_req  = (state_reg == FETCH);
  assign imem_addr = pcf_reg;

  assign InstrD   = instr_d_reg;
  assign PCD      = pc_d_reg;
  assign PCPlus4D = pc_plus4_d_reg;
  assign ValidD   = valid_d_reg;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg      <= IDLE;
      pcf_reg        <= RESET_PC;
      redir_pend_reg <= 1'b0;
      redir_pc_reg   <= 32'd0;
      buf_instr_reg  <= 32'd0;
      buf_pc_reg     <= 32'd0;
      instr_d_reg    <= NOP_INSTR;
      pc_d_reg       <= 32'd0;
      pc_plus4_d_reg <= 32'd0;
      valid_d_reg    <= 1'b0;
    end else begin
      state_reg      <= state_next;
      pcf_reg        <= pcf_next;
      redir_pend_reg <= redir_pend_next;
      redir_pc_reg   <= redir_pc_next;
      buf_instr_reg  <= buf_instr_next;
      buf_pc_reg     <= buf_pc_next;
      instr_d_reg    <= instr_d_next;
      pc_d_reg       <= pc_d_next;
      pc_plus4_d_reg <= pc_plus4_d_next;
      valid_d_reg    <= valid_d_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    pcf_next        = pcf_reg;
    redir_pend_next = redir_pend_reg;
    redir_pc_next   = redir_pc_reg;
    buf_instr_next  = buf_instr_reg;
    buf_pc_next     = buf_pc_reg;
    ifid_sel        = keep_d ? IFID_HOLD : IFID_BUBBLE;

    unique case (state_reg)
      IDLE: begin
        state_next = FETCH;
      end

      FETCH: begin
        if (!imem_ready) begin
          // Address must stay put while the request is outstanding, so park the redirect
          if (PCSrcE) begin
            redir_pend_next = 1'b1;
            redir_pc_next   = target_e;
          end
        end else if (PCSrcE || redir_pend_reg) begin
          pcf_next        = PCSrcE ? target_e : redir_pc_reg;
          redir_pend_next = 1'b0;
        end else if (FlushD) begin
          // Response discarded; the same PC is fetched again
          pcf_next = pcf_reg;
        end else if (!StallD) begin
          ifid_sel = IFID_FETCH;
          pcf_next = pcf_plus4;
        end else begin
          buf_instr_next = imem_rdata;
          buf_pc_next    = pcf_reg;
          pcf_next       = pcf_plus4;
          state_next     = HOLD;
        end
      end

      HOLD: begin
        if (PCSrcE) begin
          pcf_next       = target_e;
          buf_instr_next = 32'd0;
          buf_pc_next    = 32'd0;
          state_next     = FETCH;
        end else if (FlushD) begin
          pcf_next       = buf_pc_reg;
          buf_instr_next = 32'd0;
          buf_pc_next    = 32'd0;
          state_next     = FETCH;
        end else if (!StallD) begin
          ifid_sel   = IFID_BUF;
          state_next = FETCH;
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_comb begin
    instr_d_next    = instr_d_reg;
    pc_d_next       = pc_d_reg;
    pc_plus4_d_next = pc_plus4_d_reg;
    valid_d_next    = valid_d_reg;

    unique case (ifid_sel)
      IFID_BUBBLE: begin
        instr_d_next = NOP_INSTR;
        valid_d_next = 1'b0;
      end
      IFID_FETCH: begin
        instr_d_next    = imem_rdata;
        pc_d_next       = pcf_reg;
        pc_plus4_d_next = pcf_plus4;
        valid_d_next    = 1'b1;
      end
      IFID_BUF: begin
        instr_d_next    = buf_instr_reg;
        pc_d_next       = buf_pc_reg;
        pc_plus4_d_next = buf_pc_plus4;
        valid_d_next    = 1'b1;
      end
      default: begin
        instr_d_next = instr_d_reg;
      end
    endcase
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: memory model returns 0x100 + word index,
// bench tracks the expected fetch PC and IF/ID contents by hand.
module tb_fetch_stage;

  logic        clk;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic        StallD;
  logic        FlushD;
  logic        PCSrcE;
  logic [31:0] PCTargetE;
  logic [31:0] InstrD;
  logic [31:0] PCD;
  logic [31:0] PCPlus4D;
  logic        ValidD;

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] pc;

  localparam logic [31:0] NOP = 32'h0000_0013;

  fetch_stage dut (
    .clk        (clk),
    .reset      (reset),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ready (imem_ready),
    .imem_rdata (imem_rdata),
    .StallD     (StallD),
    .FlushD     (FlushD),
    .PCSrcE     (PCSrcE),
    .PCTargetE  (PCTargetE),
    .InstrD     (InstrD),
    .PCD        (PCD),
    .PCPlus4D   (PCPlus4D),
    .ValidD     (ValidD)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] memw(input logic [31:0] addr);
    return 32'h100 + (addr >> 2);
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end else begin
      $display("ok   %s: %h", tag, got);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // Memory answers only when a request is actually presented
  task automatic drive(input bit want);
    imem_ready = want & imem_req;
    imem_rdata = (want & imem_req) ? memw(imem_addr) : 32'hDEAD_BEEF;
  endtask

  task automatic check_ifid(input string tag, input logic [31:0] instr,
                            input logic [31:0] pcd, input logic valid);
    check({tag, ".instr"}, InstrD, instr);
    check({tag, ".pcd"}, PCD, pcd);
    check({tag, ".pc4"}, PCPlus4D, pcd + 32'd4);
    check({tag, ".valid"}, {31'd0, ValidD}, {31'd0, valid});
  endtask

  initial begin
    reset = 1'b0; imem_ready = 1'b0; imem_rdata = 32'd0;
    StallD = 1'b0; FlushD = 1'b0; PCSrcE = 1'b0; PCTargetE = 32'd0;
    step; step;
    check("rst.req", {31'd0, imem_req}, 32'd0);
    check("rst.addr", imem_addr, 32'd0);
    check("rst.instr", InstrD, NOP);
    check("rst.pcd", PCD, 32'd0);
    check("rst.pc4", PCPlus4D, 32'd0);
    check("rst.valid", {31'd0, ValidD}, 32'd0);

    // Release reset: IDLE for one edge, then first request at 0
    reset = 1'b1;
    drive(1);
    step;
    check("first.req", {31'd0, imem_req}, 32'd1);
    check("first.addr", imem_addr, 32'd0);

    // Zero-wait memory, back-to-back
    pc = 32'd0;
    for (int i = 0; i < 4; i++) begin
      drive(1);
      step;
      check_ifid("b2b", memw(pc), pc, 1'b1);
      pc = pc + 4;
    end

    // Ready every third cycle
    for (int j = 0; j < 2; j++) begin
      for (int k = 0; k < 3; k++) begin
        check("wait.addr", imem_addr, pc);
        drive(k == 2);
        step;
        if (k < 2) begin
          check("wait.instr", InstrD, NOP);
          check("wait.valid", {31'd0, ValidD}, 32'd0);
          check("wait.pcd", PCD, pc - 32'd4);
        end else begin
          check_ifid("wait.load", memw(pc), pc, 1'b1);
          pc = pc + 4;
        end
      end
    end

    // Stall while a response arrives -> HOLD, then release
    StallD = 1'b1;
    drive(1);
    step;
    check("hold.req", {31'd0, imem_req}, 32'd0);
    check_ifid("hold.frz", memw(pc - 4), pc - 4, 1'b1);
    for (int i = 0; i < 3; i++) begin
      drive(1);
      step;
      check("hold.req", {31'd0, imem_req}, 32'd0);
      check_ifid("hold.frz", memw(pc - 4), pc - 4, 1'b1);
    end
    StallD = 1'b0;
    drive(1);
    step;
    check_ifid("hold.rel", memw(pc), pc, 1'b1);
    check("hold.next", imem_addr, pc + 4);
    pc = pc + 4;
    drive(1);
    step;
    check_ifid("hold.after", memw(pc), pc, 1'b1);
    pc = pc + 4;

    // Redirect while request outstanding
    PCSrcE = 1'b1; PCTargetE = 32'h0000_0203;
    drive(0);
    step;
    PCSrcE = 1'b0; PCTargetE = 32'd0;
    check("redir.addr0", imem_addr, pc);
    check("redir.valid0", {31'd0, ValidD}, 32'd0);
    drive(0);
    step;
    check("redir.addr1", imem_addr, pc);
    drive(1);
    step;
    check("redir.valid2", {31'd0, ValidD}, 32'd0);
    check("redir.instr2", InstrD, NOP);
    check("redir.addr2", imem_addr, 32'h200);
    drive(1);
    step;
    check_ifid("redir.tgt", 32'h180, 32'h200, 1'b1);

    // Redirect coincident with ready: target requested next cycle
    PCSrcE = 1'b1; PCTargetE = 32'h40;
    drive(1);
    step;
    PCSrcE = 1'b0;
    check("pen.addr", imem_addr, 32'h40);
    check("pen.valid", {31'd0, ValidD}, 32'd0);

    // Flush and stall together: flush wins, PC refetched
    FlushD = 1'b1; StallD = 1'b1;
    drive(1);
    step;
    FlushD = 1'b0; StallD = 1'b0;
    check("flush.instr", InstrD, NOP);
    check("flush.valid", {31'd0, ValidD}, 32'd0);
    check("flush.addr", imem_addr, 32'h40);
    drive(1);
    step;
    check_ifid("flush.refetch", 32'h110, 32'h40, 1'b1);

    // PC wrap
    PCSrcE = 1'b1; PCTargetE = 32'hFFFF_FFFC;
    drive(1);
    step;
    PCSrcE = 1'b0;
    check("wrap.addr", imem_addr, 32'hFFFF_FFFC);
    drive(1);
    step;
    check("wrap.instr", InstrD, memw(32'hFFFF_FFFC));
    check("wrap.pcd", PCD, 32'hFFFF_FFFC);
    check("wrap.pc4", PCPlus4D, 32'd0);
    check("wrap.next", imem_addr, 32'd0);
    drive(1);
    step;
    check_ifid("wrap.zero", 32'h100, 32'd0, 1'b1);

    // Async reset mid-wait with IF/ID held
    StallD = 1'b1;
    drive(0);
    step;
    check("ar.pre_valid", {31'd0, ValidD}, 32'd1);
    check("ar.pre_addr", imem_addr, 32'd4);
    #2;
    reset = 1'b0;
    #1;
    check("ar.req", {31'd0, imem_req}, 32'd0);
    check("ar.addr", imem_addr, 32'd0);
    check("ar.instr", InstrD, NOP);
    check("ar.pcd", PCD, 32'd0);
    check("ar.pc4", PCPlus4D, 32'd0);
    check("ar.valid", {31'd0, ValidD}, 32'd0);
    StallD = 1'b0;
    step;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
